// File: rtl/mem_access_ctrl.sv
// Burst controller between a request/write-data/read-response handshake interface
// and a single-port Data_Memory with registered MemWrite/MemRead strobes.
module mem_access_ctrl #(
   parameter int MEM_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [1:0]  req_len,
   input  logic        wd_valid,
   output logic        wd_ready,
   input  logic [15:0] wd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_last,
   output logic        busy,
   output logic        MemWrite,
   output logic        MemRead,
   output logic [15:0] Address,
   output logic [15:0] WriteData,
   input  logic [15:0] ReadData
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WR_WAIT,
      WR_DO,
      RD_ISSUE,
      RD_CAP,
      RD_HOLD
   } state_e;

   state_e        state_q;
   logic [AW-1:0] addr_q;
   logic [1:0]    count_q;
   logic [15:0]   wdata_q;
   logic [15:0]   rsp_data_q;
   logic          mem_write_q;
   logic          mem_read_q;
   logic          rsp_valid_q;
   logic          rsp_last_q;

   // Address bits above the memory size are deliberately discarded.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[15:AW];

   // NOTE: every register, strobes included, is cleared by the synchronous reset so a
   // reset mid-burst leaves no strobe asserted after the reset edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         count_q     <= '0;
         wdata_q     <= '0;
         rsp_data_q  <= '0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so every branch reads the pre-edge state.
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr[AW-1:0];
                  count_q <= req_len;
                  if (req_write) begin
                     state_q <= WR_WAIT;
                  end else begin
                     state_q    <= RD_ISSUE;
                     mem_read_q <= 1'b1;
                  end
               end
            end
            WR_WAIT: begin
               if (wd_valid) begin
                  wdata_q     <= wd_data;
                  mem_write_q <= 1'b1;
                  state_q     <= WR_DO;
               end
            end
            WR_DO: begin
               mem_write_q <= 1'b0;
               if (count_q == 2'd0) begin
                  state_q <= IDLE;
               end else begin
                  count_q <= count_q - 2'd1;
                  addr_q  <= addr_q + 1'b1;
                  state_q <= WR_WAIT;
               end
            end
            RD_ISSUE: begin
               state_q <= RD_CAP;
            end
            RD_CAP: begin
               rsp_data_q  <= ReadData;
               mem_read_q  <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_last_q  <= (count_q == 2'd0);
               state_q     <= RD_HOLD;
            end
            RD_HOLD: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_last_q  <= 1'b0;
                  if (rsp_last_q) begin
                     state_q <= IDLE;
                  end else begin
                     count_q    <= count_q - 2'd1;
                     addr_q     <= addr_q + 1'b1;
                     mem_read_q <= 1'b1;
                     state_q    <= RD_ISSUE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Ready signals are gated by reset so nothing is offered while reset is held.
   assign req_ready = (state_q == IDLE) && reset;
   assign wd_ready  = (state_q == WR_WAIT) && reset;
   assign busy      = (state_q != IDLE);
   assign MemWrite  = mem_write_q;
   assign MemRead   = mem_read_q;
   assign Address   = {{(16 - AW){1'b0}}, addr_q};
   assign WriteData = wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = rsp_last_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 16; word count of the attached Data_Memory; power of two; burst addresses wrap modulo MEM_DEPTH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising edge of clk.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_write  input  1  1 = write burst, 0 = read burst.
REQ-007 req_addr  input  16  start word address; only low log2(MEM_DEPTH) bits used.
REQ-008 req_len  input  2  burst length minus one (1-4 words).
REQ-009 wd_valid / wd_ready / wd_data  input / output / input  1/1/16  write-data beat handshake.
REQ-010 rsp_valid / rsp_ready / rsp_data / rsp_last  output / input / output / output  1/1/16/1  read-data beat handshake; rsp_last marks final beat.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 MemWrite, MemRead  output  1 each  memory strobes.
REQ-013 Address, WriteData  output  16 each  memory address (upper bits 0) and write data.
REQ-014 ReadData  input  16  memory read data.

Function
REQ-015 FSM states SHALL be IDLE, WR_WAIT, WR_DO, RD_ISSUE, RD_CAP, RD_HOLD.
REQ-016 IDLE: req_ready=1; on req_valid&&req_ready latch addr (masked), req_len into count, req_write; next WR_WAIT (write) or RD_ISSUE (read).
REQ-017 WR_WAIT: wd_ready=1; on wd_valid latch wd_data into WriteData; next WR_DO.
REQ-018 WR_DO: MemWrite=1 for exactly one cycle, Address/WriteData stable; then count==0 -> IDLE, else count-1, addr+1 (wrap), -> WR_WAIT.
REQ-019 RD_ISSUE and RD_CAP: MemRead=1 in both cycles, Address stable; ReadData captured into rsp_data on the rising edge ending RD_CAP; next RD_HOLD.
REQ-020 RD_HOLD: MemRead=0, rsp_valid=1, rsp_data stable, rsp_last=(count==0); on rsp_ready: last -> IDLE, else count-1, addr+1 (wrap), -> RD_ISSUE.
REQ-021 Read latency: rsp_valid high 3 cycles after the accepting edge; write throughput 2 cycles/word with wd_valid held high.
REQ-022 MemWrite and MemRead SHALL never be high in the same cycle; both SHALL be registered outputs.
REQ-023 Address wrap: MEM_DEPTH-1 +1 -> 0 within a burst.
REQ-024 req_valid while busy ignored (req_ready=0); wd_valid outside WR_WAIT ignored; rsp_ready while rsp_valid=0 ignored.
REQ-025 Upper req_addr bits beyond log2(MEM_DEPTH) SHALL not affect Address.
REQ-026 Back-to-back: request accepted in the IDLE cycle directly following the final beat's return to IDLE; no extra idle cycle beyond that.

Reset
REQ-027 On a rising edge with reset=0: state=IDLE, count=0, Address=0, WriteData=0, rsp_data=0, MemWrite=0, MemRead=0, rsp_valid=0, rsp_last=0, busy=0.
REQ-028 req_ready and wd_ready SHALL be 0 while reset=0.
REQ-029 Reset mid-burst aborts immediately; no memory strobe is issued after the reset edge; remaining beats discarded.

Verification
REQ-030 Read addr 0x0000, len 0, memory word0=0x00F0 -> MemRead high 2 cycles, rsp_valid 3 cycles after accept, rsp_data=0x00F0, rsp_last=1.
REQ-031 Write addr 0x0003, len 3, data 0x1111,0x2222,0x3333,0x4444 -> four single-cycle MemWrite pulses at Address 3,4,5,6; read-back burst returns same data, rsp_last only on 4th.
REQ-032 Write addr 0x000E, len 3 -> Address sequence 14,15,0,1; req_addr 0xFFF2 len 0 -> Address=0x0002.
REQ-033 Read burst len 1 with rsp_ready low 5 cycles -> rsp_valid/rsp_data held stable, no MemRead until rsp_ready, second beat follows.
REQ-034 reset=0 during WR_WAIT of beat 2 of a 4-word write -> next cycle all outputs at reset values, no further MemWrite; new read of beat-1 address returns written value.
REQ-035 req_valid held high during a burst -> not accepted until IDLE; MemWrite&&MemRead never both 1 across all scenarios.
